// File: rtl/sprite_compositor_pkg.sv
// Shared constants and types for the sprite compositor: colours, sprite/tile geometry,
// ground band and visible screen bounds.
package sprite_compositor_pkg;

    localparam logic [11:0] SC_BLACK       = 12'h000;
    localparam logic [11:0] SC_BG_COLOR    = 12'h7AF;
    localparam logic [11:0] SC_TRANSPARENT = 12'h000;

    localparam int SC_SPR_W      = 32;
    localparam int SC_SPR_H      = 32;
    localparam int SC_TILE_SIZE  = 24;
    localparam int SC_GROUND_Y   = 460;
    localparam int SC_GROUND_END = 516;
    localparam int SC_SCREEN_L   = 144;
    localparam int SC_SCREEN_R   = 783;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       flip;
        logic       vis;
    } spr_state_t;

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: shadow/active state, hit test, mirrored ROM addressing and
// the two-stage hit delay that lines the flag up with ROM data.
module sprite_channel
    import sprite_compositor_pkg::*;
#(
    parameter int SPR_W  = SC_SPR_W,
    parameter int SPR_H  = SC_SPR_H,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fs_i,
    input  logic              wr_en_i,
    input  spr_state_t        wr_state_i,
    input  logic [9:0]        hcount_i,
    input  logic [9:0]        vcount_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              hit_d2_o
);

    localparam logic [ADDR_W-1:0] XMASK = ADDR_W'(SPR_W - 1);

    spr_state_t        pend_q, act_q, cur;
    logic              hit;
    logic [10:0]       hx, vy, x_lo, y_lo;
    logic [ADDR_W-1:0] relx, rely, addr_d, addr_q;
    logic [1:0]        hit_q;

    // The FS pixel itself must already see the state being applied this cycle.
    assign cur = fs_i ? pend_q : act_q;

    always_comb begin
        hx   = {1'b0, hcount_i};
        vy   = {1'b0, vcount_i};
        x_lo = {1'b0, cur.x};
        y_lo = {1'b0, cur.y};
        hit  = cur.vis && (hx >= x_lo) && (hx < x_lo + 11'(SPR_W))
                       && (vy >= y_lo) && (vy < y_lo + 11'(SPR_H));
        relx = ADDR_W'(hcount_i - cur.x) & XMASK;
        if (cur.flip)
            relx = XMASK - relx;
        rely   = ADDR_W'(vcount_i - cur.y);
        addr_d = hit ? (rely * ADDR_W'(SPR_W) + relx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            act_q  <= '0;
            addr_q <= '0;
            hit_q  <= '0;
        end else begin
            if (wr_en_i)
                pend_q <= wr_state_i;
            if (fs_i)
                act_q <= pend_q;
            addr_q <= addr_d;
            hit_q  <= {hit_q[0], hit};
        end
    end

    assign addr_o   = addr_q;
    assign hit_d2_o = hit_q[1];

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite pixel pipeline: sprite channels, ground tile addressing, priority
// compose into rgb (3 clk latency) and per-frame opaque-overlap reporting.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPR_W       = SC_SPR_W,
    parameter int          SPR_H       = SC_SPR_H,
    parameter int          ADDR_W      = 10,
    parameter int          TILE_SIZE   = SC_TILE_SIZE,
    parameter int          GROUND_Y    = SC_GROUND_Y,
    parameter int          GROUND_END  = SC_GROUND_END,
    parameter logic [11:0] TRANSPARENT = SC_TRANSPARENT,
    parameter logic [11:0] BG_COLOR    = SC_BG_COLOR,
    localparam int         IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bright,
    input  logic [9:0]                    hCount,
    input  logic [9:0]                    vCount,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [9:0]                    wr_x,
    input  logic [9:0]                    wr_y,
    input  logic                          wr_flip,
    input  logic                          wr_vis,
    output logic [NUM_SPRITES*ADDR_W-1:0] spr_addr,
    input  logic [NUM_SPRITES*12-1:0]     spr_data,
    output logic [9:0]                    tile_addr,
    input  logic [11:0]                   tile_data,
    output logic [11:0]                   rgb,
    output logic [NUM_SPRITES-1:0]        collide_mask,
    output logic                          collide_valid
);

    logic                                fs;
    spr_state_t                          wr_state;
    logic [NUM_SPRITES-1:0][ADDR_W-1:0]  ch_addr;
    logic [NUM_SPRITES-1:0][11:0]        ch_data;
    logic [NUM_SPRITES-1:0]              hit_d2, opaque, coll;

    logic       in_ground;
    logic [9:0] gy, tile_row, tile_col, tile_addr_d, tile_addr_q;
    logic [1:0] ground_q, bright_q;
    logic [11:0] rgb_d, rgb_q;
    logic [NUM_SPRITES-1:0] acc_q, mask_q;
    logic       valid_q;

    assign fs       = (hCount == 10'd0) && (vCount == 10'd0);
    assign wr_state = '{x: wr_x, y: wr_y, flip: wr_flip, vis: wr_vis};
    assign ch_data  = spr_data;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_ch
        sprite_channel #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H),
            .ADDR_W(ADDR_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .fs_i      (fs),
            .wr_en_i   (wr_en && (wr_idx == IDX_W'(i))),
            .wr_state_i(wr_state),
            .hcount_i  (hCount),
            .vcount_i  (vCount),
            .addr_o    (ch_addr[i]),
            .hit_d2_o  (hit_d2[i])
        );
    end

    always_comb begin
        in_ground   = (vCount >= 10'(GROUND_Y)) && (vCount <= 10'(GROUND_END));
        gy          = vCount - 10'(GROUND_Y);
        tile_row    = gy % 10'(TILE_SIZE);
        tile_col    = hCount % 10'(TILE_SIZE);
        tile_addr_d = in_ground ? (tile_row * 10'(TILE_SIZE) + tile_col) : '0;
    end

    // Stage 2 compose; walking from the highest index down leaves channel 0 on top.
    always_comb begin
        int cnt;
        cnt    = 0;
        opaque = '0;
        rgb_d  = BG_COLOR;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            opaque[i] = hit_d2[i] && (ch_data[i] != TRANSPARENT);
            cnt       = cnt + int'(opaque[i]);
        end
        if (!bright_q[1]) begin
            rgb_d = SC_BLACK;
        end else begin
            if (ground_q[1] && (tile_data != TRANSPARENT))
                rgb_d = tile_data;
            for (int i = NUM_SPRITES - 1; i >= 0; i--)
                if (opaque[i])
                    rgb_d = ch_data[i];
        end
        coll = (bright_q[1] && (cnt >= 2)) ? opaque : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_addr_q <= '0;
            ground_q    <= '0;
            bright_q    <= '0;
            rgb_q       <= '0;
            acc_q       <= '0;
            mask_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            tile_addr_q <= tile_addr_d;
            ground_q    <= {ground_q[0], in_ground};
            bright_q    <= {bright_q[0], bright};
            rgb_q       <= rgb_d;
            valid_q     <= fs;
            // Overlaps seen on the FS cycle belong to the frame that starts there.
            if (fs) begin
                mask_q <= acc_q;
                acc_q  <= coll;
            end else begin
                acc_q  <= acc_q | coll;
            end
        end
    end

    assign spr_addr      = ch_addr;
    assign tile_addr     = tile_addr_q;
    assign rgb           = rgb_q;
    assign collide_mask  = mask_q;
    assign collide_valid = valid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: reset, placement, flip, priority,
// collision reporting, wrap edge and ground tiles.
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bright = 1'b1;
    logic [9:0]  hCount = 10'd300, vCount = 10'd400;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_idx = '0;
    logic [9:0]  wr_x = '0, wr_y = '0;
    logic        wr_flip = 1'b0, wr_vis = 1'b0;
    logic [39:0] spr_addr;
    logic [47:0] spr_data = '0;
    logic [9:0]  tile_addr;
    logic [11:0] tile_data = '0;
    logic [11:0] rgb;
    logic [3:0]  collide_mask;
    logic        collide_valid;

    logic [11:0] col [4];
    logic [11:0] tile_col = 12'h0A5;
    logic [39:0] s_addr;
    logic [9:0]  s_tile;
    logic [11:0] s_rgb;
    int          total = 0, bad = 0;

    sprite_compositor dut (
        .clk(clk), .rst_n(rst_n), .bright(bright), .hCount(hCount), .vCount(vCount),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_flip(wr_flip),
        .wr_vis(wr_vis), .spr_addr(spr_addr), .spr_data(spr_data), .tile_addr(tile_addr),
        .tile_data(tile_data), .rgb(rgb), .collide_mask(collide_mask),
        .collide_valid(collide_valid)
    );

    always #5 clk = ~clk;

    // ROM models: constant colour per channel, one clk behind the address.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) spr_data[i*12 +: 12] <= col[i];
        tile_data <= tile_col;
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hCount = 10'd799; vCount = 10'd524; bright = 1'b0;
    endtask

    // Present one pixel, then idle; addresses after 1 clk, colour after 3 clk.
    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic b);
        @(negedge clk); hCount = h; vCount = v; bright = b;
        @(negedge clk); s_addr = spr_addr; s_tile = tile_addr; idle();
        @(negedge clk);
        @(negedge clk); s_rgb = rgb;
    endtask

    task automatic wr(input int idx, input int x, input int y, input logic f, input logic vs);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 2'(idx); wr_x = 10'(x); wr_y = 10'(y); wr_flip = f; wr_vis = vs;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic frame(input string tag, input logic [3:0] exp_mask);
        @(negedge clk); hCount = 10'd0; vCount = 10'd0; bright = 1'b0;
        @(negedge clk); idle();
        chk({tag, "_valid"}, 40'(collide_valid), 40'd1);
        chk({tag, "_mask"}, 40'(collide_mask), 40'(exp_mask));
        @(negedge clk);
        chk({tag, "_pulse"}, 40'(collide_valid), 40'd0);
    endtask

    initial begin
        col[0] = 12'hF00; col[1] = 12'h0F0; col[2] = 12'h00F; col[3] = 12'hFFF;
        repeat (3) @(negedge clk);
        chk("rst_rgb", 40'(rgb), 40'h0);
        chk("rst_spr_addr", spr_addr, 40'h0);
        chk("rst_tile_addr", 40'(tile_addr), 40'h0);
        chk("rst_mask", 40'(collide_mask), 40'h0);
        chk("rst_valid", 40'(collide_valid), 40'h0);
        @(negedge clk); rst_n = 1'b1; idle();

        pix(10'd100, 10'd100, 1'b1);
        chk("sky_rgb", 40'(s_rgb), 40'h7AF);
        pix(10'd300, 10'd400, 1'b1);
        chk("novis_rgb", 40'(s_rgb), 40'h7AF);

        wr(0, 300, 400, 1'b0, 1'b1);
        pix(10'd300, 10'd400, 1'b1);
        chk("pending_rgb", 40'(s_rgb), 40'h7AF);
        frame("fs1", 4'b0000);

        pix(10'd300, 10'd400, 1'b1);
        chk("s0_rgb", 40'(s_rgb), 40'hF00);
        chk("s0_addr", 40'(s_addr[9:0]), 40'd0);
        pix(10'd299, 10'd400, 1'b1);
        chk("s0_left", 40'(s_rgb), 40'h7AF);
        pix(10'd331, 10'd431, 1'b1);
        chk("s0_br_rgb", 40'(s_rgb), 40'hF00);
        chk("s0_br_addr", 40'(s_addr[9:0]), 40'd1023);
        pix(10'd332, 10'd400, 1'b1);
        chk("s0_right", 40'(s_rgb), 40'h7AF);
        pix(10'd300, 10'd432, 1'b1);
        chk("s0_below", 40'(s_rgb), 40'h7AF);
        pix(10'd300, 10'd400, 1'b0);
        chk("blank_rgb", 40'(s_rgb), 40'h0);

        wr(0, 300, 400, 1'b1, 1'b1);
        frame("fs2", 4'b0000);
        pix(10'd300, 10'd401, 1'b1);
        chk("flip_l_addr", 40'(s_addr[9:0]), 40'd63);
        chk("flip_l_rgb", 40'(s_rgb), 40'hF00);
        pix(10'd331, 10'd401, 1'b1);
        chk("flip_r_addr", 40'(s_addr[9:0]), 40'd32);

        wr(0, 300, 400, 1'b0, 1'b1);
        wr(1, 300, 400, 1'b0, 1'b1);
        col[0] = 12'h000;
        frame("fs3", 4'b0000);
        pix(10'd300, 10'd400, 1'b1);
        chk("transp_rgb", 40'(s_rgb), 40'h0F0);
        chk("ch1_addr", 40'(s_addr[19:10]), 40'd0);
        frame("fs4_transp", 4'b0000);

        col[0] = 12'hF00;
        pix(10'd300, 10'd400, 1'b1);
        chk("prio_rgb", 40'(s_rgb), 40'hF00);
        frame("fs5_overlap", 4'b0011);

        wr(1, 600, 400, 1'b0, 1'b1);
        frame("fs6", 4'b0000);
        pix(10'd300, 10'd400, 1'b1);
        chk("apart0_rgb", 40'(s_rgb), 40'hF00);
        pix(10'd600, 10'd400, 1'b1);
        chk("apart1_rgb", 40'(s_rgb), 40'h0F0);
        frame("fs7_apart", 4'b0000);

        wr(2, 1000, 400, 1'b0, 1'b1);
        frame("fs8", 4'b0000);
        for (int h = 0; h < 8; h += 5) begin
            pix(10'(h), 10'd400, 1'b1);
            chk("nowrap_rgb", 40'(s_rgb), 40'h7AF);
            chk("nowrap_addr", 40'(s_addr[29:20]), 40'd0);
        end
        pix(10'd1001, 10'd401, 1'b1);
        chk("far_rgb", 40'(s_rgb), 40'h00F);
        chk("far_addr", 40'(s_addr[29:20]), 40'd33);

        pix(10'd50, 10'd484, 1'b1);
        chk("gnd_addr", 40'(s_tile), 40'd2);
        chk("gnd_rgb", 40'(s_rgb), 40'h0A5);
        pix(10'd50, 10'd460, 1'b1);
        chk("gnd_top", 40'(s_tile), 40'd2);
        pix(10'd0, 10'd516, 1'b1);
        chk("gnd_bot_addr", 40'(s_tile), 40'd192);
        chk("gnd_bot_rgb", 40'(s_rgb), 40'h0A5);
        pix(10'd50, 10'd517, 1'b1);
        chk("gnd_past_addr", 40'(s_tile), 40'd0);
        chk("gnd_past_rgb", 40'(s_rgb), 40'h7AF);
        pix(10'd50, 10'd459, 1'b1);
        chk("gnd_pre_addr", 40'(s_tile), 40'd0);
        tile_col = 12'h000;
        pix(10'd50, 10'd484, 1'b1);
        chk("gnd_transp", 40'(s_rgb), 40'h7AF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
